// File: rtl/axi4_if.sv
// AXI4 bus bundle shared by masters and slaves.
// Modports: master drives AW/W/AR and B/R ready; slave drives the rest.
interface axi4_if #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 5
);
  logic [AXI4_ADDRESS_WIDTH-1:0]  awaddr;
  logic [AXI4_ID_WIDTH-1:0]       awid;
  logic [7:0]                     awlen;
  logic [2:0]                     awsize;
  logic [1:0]                     awburst;
  logic                           awvalid;
  logic                           awready;
  logic [AXI4_DATA_WIDTH-1:0]     wdata;
  logic [AXI4_DATA_WIDTH/8-1:0]   wstrb;
  logic                           wlast;
  logic                           wvalid;
  logic                           wready;
  logic [AXI4_ID_WIDTH-1:0]       bid;
  logic [1:0]                     bresp;
  logic                           bvalid;
  logic                           bready;
  logic [AXI4_ADDRESS_WIDTH-1:0]  araddr;
  logic [AXI4_ID_WIDTH-1:0]       arid;
  logic [7:0]                     arlen;
  logic [2:0]                     arsize;
  logic [1:0]                     arburst;
  logic                           arvalid;
  logic                           arready;
  logic [AXI4_ID_WIDTH-1:0]       rid;
  logic [AXI4_DATA_WIDTH-1:0]     rdata;
  logic [1:0]                     rresp;
  logic                           rlast;
  logic                           rvalid;
  logic                           rready;

  modport master (
    output awaddr, awid, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output araddr, arid, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awid, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  araddr, arid, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_gpio.sv
// AXI4 slave GPIO: OUT (0x0), IN (0x4), IRQ_EN (0x8), IRQ_STAT W1C (0xC).
// Ports: clk, rst (async high), s (axi4_if.slave), gpio_in, gpio_out, irq.
// Macro AXI4_GPIO_IRQ_EN builds IRQ_EN/IRQ_STAT, edge detect and irq.
module axi4_gpio #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 5,
  parameter int GPIO_WIDTH         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  axi4_if.slave                 s,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  irq
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e                    wstate_q, wstate_d;
  logic [1:0]                 widx_q, widx_d;
  logic [7:0]                 wcnt_q, wcnt_d;
  logic [7:0]                 wlen_q, wlen_d;
  logic [AXI4_ID_WIDTH-1:0]   bid_q, bid_d;
  rstate_e                    rstate_q, rstate_d;
  logic [1:0]                 ridx_q, ridx_d;
  logic [7:0]                 rcnt_q, rcnt_d;
  logic [7:0]                 rlen_q, rlen_d;
  logic [AXI4_ID_WIDTH-1:0]   rid_q, rid_d;
  logic [AXI4_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [GPIO_WIDTH-1:0]      out_q, out_d;
  logic [GPIO_WIDTH-1:0]      sync1_q, in_q;
  logic [GPIO_WIDTH-1:0]      bm;
  logic                       we;
  logic [AXI4_DATA_WIDTH-1:0] regv [4];

`ifdef AXI4_GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0]      en_q, en_d;
  logic [GPIO_WIDTH-1:0]      stat_q, stat_d;
  logic [GPIO_WIDTH-1:0]      prev_q;
  logic [GPIO_WIDTH-1:0]      rise, clr;
`endif

  // Per-bit write mask from byte strobes.
  always_comb begin
    bm = '0;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      bm[i] = s.wstrb[i/8];
    end
  end

  assign we = (wstate_q == W_DATA) && s.wvalid;

  // Read view of the register file; unused upper bits read 0.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      regv[k] = '0;
    end
    regv[0][GPIO_WIDTH-1:0] = out_q;
    regv[1][GPIO_WIDTH-1:0] = in_q;
`ifdef AXI4_GPIO_IRQ_EN
    regv[2][GPIO_WIDTH-1:0] = en_q;
    regv[3][GPIO_WIDTH-1:0] = stat_q;
`endif
  end

  always_comb begin
    out_d = out_q;
    if (we && widx_q == 2'd0) begin
      out_d = (out_q & ~bm) | (s.wdata[GPIO_WIDTH-1:0] & bm);
    end
  end

`ifdef AXI4_GPIO_IRQ_EN
  // A rising edge in the same cycle as a clear wins.
  always_comb begin
    en_d = en_q;
    clr  = '0;
    rise = in_q & ~prev_q;
    if (we && widx_q == 2'd2) begin
      en_d = (en_q & ~bm) | (s.wdata[GPIO_WIDTH-1:0] & bm);
    end
    if (we && widx_q == 2'd3) begin
      clr = s.wdata[GPIO_WIDTH-1:0] & bm;
    end
    stat_d = (stat_q & ~clr) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= '0;
      stat_q <= '0;
      prev_q <= '0;
    end else begin
      en_q   <= en_d;
      stat_q <= stat_d;
      prev_q <= in_q;
    end
  end

  assign irq = |(stat_q & en_q);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    wstate_d = wstate_q;
    widx_d   = widx_q;
    wcnt_d   = wcnt_q;
    wlen_d   = wlen_q;
    bid_d    = bid_q;
    case (wstate_q)
      W_IDLE: begin
        if (s.awvalid) begin
          widx_d   = s.awaddr[3:2];
          wcnt_d   = '0;
          wlen_d   = s.awlen;
          bid_d    = s.awid;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s.wvalid) begin
          widx_d = widx_q + 2'd1;
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_q == wlen_q) begin
            wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s.bready) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Each beat's data is captured from regv at its load cycle.
  always_comb begin
    rstate_d = rstate_q;
    ridx_d   = ridx_q;
    rcnt_d   = rcnt_q;
    rlen_d   = rlen_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        if (s.arvalid) begin
          ridx_d   = s.araddr[3:2];
          rcnt_d   = '0;
          rlen_d   = s.arlen;
          rid_d    = s.arid;
          rdata_d  = regv[s.araddr[3:2]];
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s.rready) begin
          if (rcnt_q == rlen_q) begin
            rstate_d = R_IDLE;
          end else begin
            ridx_d  = ridx_q + 2'd1;
            rcnt_d  = rcnt_q + 8'd1;
            rdata_d = regv[ridx_q + 2'd1];
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q <= W_IDLE;
      widx_q   <= '0;
      wcnt_q   <= '0;
      wlen_q   <= '0;
      bid_q    <= '0;
      rstate_q <= R_IDLE;
      ridx_q   <= '0;
      rcnt_q   <= '0;
      rlen_q   <= '0;
      rid_q    <= '0;
      rdata_q  <= '0;
      out_q    <= '0;
      sync1_q  <= '0;
      in_q     <= '0;
    end else begin
      wstate_q <= wstate_d;
      widx_q   <= widx_d;
      wcnt_q   <= wcnt_d;
      wlen_q   <= wlen_d;
      bid_q    <= bid_d;
      rstate_q <= rstate_d;
      ridx_q   <= ridx_d;
      rcnt_q   <= rcnt_d;
      rlen_q   <= rlen_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      out_q    <= out_d;
      sync1_q  <= gpio_in;
      in_q     <= sync1_q;
    end
  end

  assign s.awready = (wstate_q == W_IDLE);
  assign s.wready  = (wstate_q == W_DATA);
  assign s.bvalid  = (wstate_q == W_RESP);
  assign s.bid     = bid_q;
  assign s.bresp   = 2'b00;
  assign s.arready = (rstate_q == R_IDLE);
  assign s.rvalid  = (rstate_q == R_DATA);
  assign s.rlast   = (rstate_q == R_DATA) && (rcnt_q == rlen_q);
  assign s.rid     = rid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = 2'b00;
  assign gpio_out  = out_q;

endmodule
